display: RTL

DISPLAY -- requirements
Module: display

---
 rtl/display.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/display.sv
// display: byte FIFO fed from a shared 16-bit bus, drained by a UART-style
// serial transmitter (start, 8 data bits LSB first, optional parity, stop).
// Optional feature macro: DISPLAY_PARITY_EN adds an even-parity bit per frame.
module display #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              in,
    input  logic                     dsp_in_en,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef DISPLAY_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    head;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef DISPLAY_PARITY_EN
    logic          par;
`endif

    logic baud_last, pop, push, drop;

    // Upper bus byte belongs to other consumers of the shared bus.
    logic unused_hi;
    assign unused_hi = ^in[15:8];

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    assign baud_last = (baud == BW'(CLKS_PER_BIT - 1));

    // The transmitter takes a byte either from idle or at the final stop cycle,
    // so back-to-back frames leave no idle gap. Pops use registered occupancy,
    // so a freshly written byte is never bypassed the same cycle.
    assign pop  = !empty && ((state == IDLE) || (state == STOP && baud_last));
    assign push = dsp_in_en && (!full || pop);
    assign drop = dsp_in_en && full && !pop;

    // FIFO storage; no reset needed since pointers/count qualify its contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // Transmit FSM with registered tx/busy; baud counter restarts on every state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef DISPLAY_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= head;
`ifdef DISPLAY_PARITY_EN
                        par   <= ^head;
`endif
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        baud  <= '0;
                    end
                end
                START: begin
                    if (baud_last) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef DISPLAY_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`ifdef DISPLAY_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        state <= STOP;
                        baud  <= '0;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
`ifdef DISPLAY_PARITY_EN
                            par   <= ^head;
`endif
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule
